// File: rtl/dlx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dlx_ctrl_pkg
// Shared definitions for the DLX trap/interrupt sequencer:
//   - ctrl_state_t     : sequencer states (IDLE/SAVE/VECTOR/RESTORE)
//   - CAUSE_TRAP       : cause code of a TRAP instruction (IRQ n reports n+1)
//   - VEC_STRIDE       : spacing of vector table slots in bytes
//   - VEC_BASE_DEFAULT : default base address of the vector table
//   - vec_slot_addr()  : base + stride * slot, 32-bit, wrap-around ignored
// -----------------------------------------------------------------------------
package dlx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_VECTOR  = 2'd2,
      ST_RESTORE = 2'd3
   } ctrl_state_t;

   localparam int          CAUSE_TRAP       = 0;
   localparam int          CAUSE_IRQ_BASE   = 1;
   localparam logic [31:0] VEC_STRIDE       = 32'd16;
   localparam logic [31:0] VEC_BASE_DEFAULT = 32'h0000_0100;

   function automatic logic [31:0] vec_slot_addr(input logic [31:0] base,
                                                 input logic [31:0] slot);
      return base + VEC_STRIDE * slot;
   endfunction

endpackage

// File: rtl/dlx_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// dlx_irq_prio_enc
// Combinational fixed-priority encoder; input 0 has the highest priority.
// Ports:
//   req   in  N   request lines
//   valid out 1   at least one request set
//   idx   out IW  index of the lowest set request (0 when none)
// -----------------------------------------------------------------------------
module dlx_irq_prio_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // Scanning from the top down lets the lowest set index win.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IW'(i);
      end
   end

   assign valid = |req;

endmodule

// File: rtl/dlx_trap_ctrl.sv
// -----------------------------------------------------------------------------
// dlx_trap_ctrl
// Trap/interrupt sequencer for the non-pipelined DLX. At an instruction
// boundary it takes a TRAP, an RFE or an enabled external interrupt, borrows
// the S1/S2/dest datapath for one or two cycles and stalls the main FSM
// through busy.
//
// Build option: define DLX_IRQ_VECTORED_EN to give each interrupt line its own
// vector (VEC_BASE + 16*(n+1)); otherwise all interrupts share VEC_BASE + 16.
//
// Ports:
//   clock, reset        clock; asynchronous active-high reset
//   instr_done          last cycle of an instruction (requests sampled here)
//   trap_req, rfe_req   current instruction is TRAP / RFE
//   irq[NUM_IRQ]        level-sensitive interrupt lines
//   irq_ack[NUM_IRQ]    one-cycle acknowledge of the granted line
//   busy                sequencer owns the datapath
//   pc_oeS1, IARoeS1    PC / IAR drive the S1 bus
//   IAR_load, pc_load   IAR / PC capture the dest bus
//   alu_pass_s1/_s2     ALU forwards S1 / S2 to dest
//   s2_bus[32]          tri-state, vector address in VECTOR
//   int_en              global interrupt enable
//   cause               last taken cause: 0 = TRAP, n+1 = irq[n]
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for instr_done; all controls low, s2_bus released
// ST_SAVE    | PC -> S1 -> dest -> IAR; int_en clears at end of cycle
// ST_VECTOR  | vector -> S2 -> dest -> PC; ack pulse for an IRQ cause
// ST_RESTORE | IAR -> S1 -> dest -> PC; int_en sets at end of cycle
// -----------------------------------------------------------------------------
module dlx_trap_ctrl
   import dlx_ctrl_pkg::*;
#(
   parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT,
   parameter int          NUM_IRQ  = 4,
   localparam int         CW       = $clog2(NUM_IRQ + 1),
   localparam int         IW       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               instr_done,
   input  logic               trap_req,
   input  logic               rfe_req,
   input  logic [NUM_IRQ-1:0] irq,
   output logic [NUM_IRQ-1:0] irq_ack,
   output logic               busy,
   output logic               pc_oeS1,
   output logic               IARoeS1,
   output logic               IAR_load,
   output logic               pc_load,
   output logic               alu_pass_s1,
   output logic               alu_pass_s2,
   output logic [31:0]        s2_bus,
   output logic               int_en,
   output logic [CW-1:0]      cause
);

   ctrl_state_t   state, state_nxt;
   logic [IW-1:0] grant_idx;
   logic          irq_valid;
   logic [IW-1:0] irq_idx;
   logic          take_trap;
   logic          take_irq;
   logic          s2_drive;
   logic [31:0]   vec_addr;

   dlx_irq_prio_enc #(
      .N  (NUM_IRQ),
      .IW (IW)
   ) u_prio (
      .req   (irq),
      .valid (irq_valid),
      .idx   (irq_idx)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         int_en    <= 1'b1;
         cause     <= CW'(CAUSE_TRAP);
         grant_idx <= '0;
      end else begin
         state <= state_nxt;
         if (take_trap) begin
            cause <= CW'(CAUSE_TRAP);
         end else if (take_irq) begin
            cause     <= CW'(irq_idx) + CW'(CAUSE_IRQ_BASE);
            grant_idx <= irq_idx;
         end
         if (state == ST_SAVE) begin
            int_en <= 1'b0;
         end else if (state == ST_RESTORE) begin
            int_en <= 1'b1;
         end
      end
   end

   // Next state; TRAP beats RFE, and both beat an interrupt.
   always_comb begin
      state_nxt = state;
      take_trap = 1'b0;
      take_irq  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (instr_done) begin
               if (trap_req) begin
                  take_trap = 1'b1;
                  state_nxt = ST_SAVE;
               end else if (rfe_req) begin
                  state_nxt = ST_RESTORE;
               end else if (int_en && irq_valid) begin
                  take_irq  = 1'b1;
                  state_nxt = ST_SAVE;
               end
            end
         end
         ST_SAVE:    state_nxt = ST_VECTOR;
         ST_VECTOR:  state_nxt = ST_IDLE;
         ST_RESTORE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Moore outputs from the registered state.
   always_comb begin
      busy        = 1'b0;
      pc_oeS1     = 1'b0;
      IARoeS1     = 1'b0;
      IAR_load    = 1'b0;
      pc_load     = 1'b0;
      alu_pass_s1 = 1'b0;
      alu_pass_s2 = 1'b0;
      s2_drive    = 1'b0;
      irq_ack     = '0;
      case (state)
         ST_SAVE: begin
            busy        = 1'b1;
            pc_oeS1     = 1'b1;
            alu_pass_s1 = 1'b1;
            IAR_load    = 1'b1;
         end
         ST_VECTOR: begin
            busy        = 1'b1;
            alu_pass_s2 = 1'b1;
            pc_load     = 1'b1;
            s2_drive    = 1'b1;
            if (cause != CW'(CAUSE_TRAP)) begin
               for (int i = 0; i < NUM_IRQ; i++) begin
                  irq_ack[i] = (grant_idx == IW'(i));
               end
            end
         end
         ST_RESTORE: begin
            busy        = 1'b1;
            IARoeS1     = 1'b1;
            alu_pass_s1 = 1'b1;
            pc_load     = 1'b1;
         end
         default: ;
      endcase
   end

   // cause already equals the slot number for an IRQ (n+1), so the vectored
   // build uses it directly as the table index.
   always_comb begin
      vec_addr = VEC_BASE;
      if (cause != CW'(CAUSE_TRAP)) begin
`ifdef DLX_IRQ_VECTORED_EN
         vec_addr = vec_slot_addr(VEC_BASE, 32'(cause));
`else
         vec_addr = vec_slot_addr(VEC_BASE, 32'(CAUSE_IRQ_BASE));
`endif
      end
   end

   assign s2_bus = s2_drive ? vec_addr : 32'bz;

endmodule

// File: tb/tb_dlx_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dlx_trap_ctrl
// Bench for dlx_trap_ctrl. It owns a tiny PC/IAR datapath driven by the DUT
// controls and predicts every result from the instruction-boundary rules.
// -----------------------------------------------------------------------------
module tb_dlx_trap_ctrl;

   localparam logic [31:0] VB = 32'h0000_0100;

   // {busy, pc_oeS1, IARoeS1, IAR_load, pc_load, alu_pass_s1, alu_pass_s2}
   localparam logic [6:0] C_IDLE    = 7'b0000000;
   localparam logic [6:0] C_SAVE    = 7'b1101010;
   localparam logic [6:0] C_VECTOR  = 7'b1000101;
   localparam logic [6:0] C_RESTORE = 7'b1010110;

   logic        clock = 1'b0;
   logic        reset;
   logic        instr_done, trap_req, rfe_req;
   logic [3:0]  irq;
   wire  [3:0]  irq_ack;
   wire         busy, pc_oeS1, IARoeS1, IAR_load, pc_load;
   wire         alu_pass_s1, alu_pass_s2, int_en;
   wire  [31:0] s2_bus;
   wire  [2:0]  cause;

   dlx_trap_ctrl dut (
      .clock       (clock),
      .reset       (reset),
      .instr_done  (instr_done),
      .trap_req    (trap_req),
      .rfe_req     (rfe_req),
      .irq         (irq),
      .irq_ack     (irq_ack),
      .busy        (busy),
      .pc_oeS1     (pc_oeS1),
      .IARoeS1     (IARoeS1),
      .IAR_load    (IAR_load),
      .pc_load     (pc_load),
      .alu_pass_s1 (alu_pass_s1),
      .alu_pass_s2 (alu_pass_s2),
      .s2_bus      (s2_bus),
      .int_en      (int_en),
      .cause       (cause)
   );

   always #5 clock = ~clock;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] pc, iar;
   logic        m_int_en;
   logic [2:0]  m_cause;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ctl();
      return {busy, pc_oeS1, IARoeS1, IAR_load, pc_load, alu_pass_s1, alu_pass_s2};
   endfunction

   // A released bus reads as Z in four-state simulators and 0 in two-state.
   task automatic chk_s2_free(input string tag);
      logic ok;
      ok = (s2_bus === 32'bz) || (s2_bus === 32'b0);
      chk(tag, {31'b0, ok}, 32'd1);
   endtask

   function automatic logic [31:0] exp_vec(input logic [2:0] c);
      if (c == 3'd0) return VB;
`ifdef DLX_IRQ_VECTORED_EN
      return VB + 32'd16 * {29'b0, c};
`else
      return VB + 32'd16;
`endif
   endfunction

   // One clock of the environment datapath: dest = S1 or S2 as selected.
   task automatic tick();
      logic [31:0] s1, d;
      logic        li, lp;
      s1 = pc_oeS1 ? pc : (IARoeS1 ? iar : 32'd0);
      d  = alu_pass_s1 ? s1 : (alu_pass_s2 ? s2_bus : 32'd0);
      li = IAR_load;
      lp = pc_load;
      @(posedge clock);
      if (li) iar = d;
      if (lp) pc = d;
      #1;
   endtask

   // Present one instruction boundary and follow the whole response.
   task automatic do_instr(input logic t, input logic r, input logic [3:0] iv, input string tag);
      int          kind;
      int          n;
      logic [31:0] pc0, iar0, vec;
      logic [3:0]  exp_ack;
      logic        en0;
      pc0     = pc;
      iar0    = iar;
      en0     = m_int_en;
      exp_ack = 4'b0;
      kind    = 0;
      if (t) begin
         kind    = 1;
         m_cause = 3'd0;
      end else if (r) begin
         kind = 2;
      end else if (m_int_en && iv != 4'b0) begin
         kind = 1;
         n = 3;
         for (int i = 3; i >= 0; i--) if (iv[i]) n = i;
         m_cause = 3'(n + 1);
         exp_ack = 4'(1 << n);
      end
      vec = exp_vec(m_cause);
      instr_done = 1'b1; trap_req = t; rfe_req = r; irq = iv;
      tick();
      instr_done = 1'b0; trap_req = 1'b0; rfe_req = 1'b0;
      chk({tag, "_cause"}, {29'b0, cause}, {29'b0, m_cause});
      if (kind == 1) begin
         chk({tag, "_save_ctl"}, {25'b0, ctl()}, {25'b0, C_SAVE});
         chk({tag, "_save_ack"}, {28'b0, irq_ack}, 32'd0);
         chk_s2_free({tag, "_save_s2"});
         chk({tag, "_save_inten"}, {31'b0, int_en}, {31'b0, en0});
         tick();
         m_int_en = 1'b0;
         chk({tag, "_iar"}, iar, pc0);
         chk({tag, "_inten_off"}, {31'b0, int_en}, 32'd0);
         chk({tag, "_vec_ctl"}, {25'b0, ctl()}, {25'b0, C_VECTOR});
         chk({tag, "_s2"}, s2_bus, vec);
         chk({tag, "_ack"}, {28'b0, irq_ack}, {28'b0, exp_ack});
         tick();
         chk({tag, "_pc"}, pc, vec);
         chk({tag, "_end_ctl"}, {25'b0, ctl()}, {25'b0, C_IDLE});
         chk({tag, "_end_ack"}, {28'b0, irq_ack}, 32'd0);
      end else if (kind == 2) begin
         chk({tag, "_rst_ctl"}, {25'b0, ctl()}, {25'b0, C_RESTORE});
         chk_s2_free({tag, "_rst_s2"});
         tick();
         m_int_en = 1'b1;
         chk({tag, "_pc"}, pc, iar0);
         chk({tag, "_inten_on"}, {31'b0, int_en}, 32'd1);
         chk({tag, "_end_ctl"}, {25'b0, ctl()}, {25'b0, C_IDLE});
      end else begin
         chk({tag, "_none_ctl"}, {25'b0, ctl()}, {25'b0, C_IDLE});
         chk({tag, "_none_ack"}, {28'b0, irq_ack}, 32'd0);
         chk({tag, "_none_inten"}, {31'b0, int_en}, {31'b0, m_int_en});
      end
   endtask

   initial begin
      reset = 1'b1; instr_done = 1'b0; trap_req = 1'b0; rfe_req = 1'b0; irq = 4'b0;
      pc = 32'h40; iar = 32'h0; m_int_en = 1'b1; m_cause = 3'd0;
      @(posedge clock); @(posedge clock); #1;
      chk("reset_ctl", {25'b0, ctl()}, {25'b0, C_IDLE});
      chk("reset_ack", {28'b0, irq_ack}, 32'd0);
      chk("reset_inten", {31'b0, int_en}, 32'd1);
      chk("reset_cause", {29'b0, cause}, 32'd0);
      chk_s2_free("reset_s2");
      reset = 1'b0;
      tick();

      do_instr(1'b1, 1'b0, 4'b0000, "trap");
      do_instr(1'b0, 1'b1, 4'b0000, "rfe");
      do_instr(1'b0, 1'b0, 4'b0110, "irq0110");
      do_instr(1'b0, 1'b0, 4'b0001, "masked");
      do_instr(1'b0, 1'b1, 4'b0001, "rfe_over_irq");
      do_instr(1'b0, 1'b0, 4'b0001, "irq0001");
      do_instr(1'b0, 1'b1, 4'b0000, "rfe2");
      do_instr(1'b1, 1'b0, 4'b1000, "trap_irq");
      do_instr(1'b0, 1'b0, 4'b1000, "pend_blocked");
      do_instr(1'b1, 1'b1, 4'b0000, "trap_rfe");
      do_instr(1'b0, 1'b1, 4'b0000, "rfe3");

      // Reset in the middle of VECTOR for an interrupt.
      instr_done = 1'b1; irq = 4'b0100;
      tick();
      instr_done = 1'b0;
      tick();
      chk("midvec_pre_ctl", {25'b0, ctl()}, {25'b0, C_VECTOR});
      chk("midvec_pre_ack", {28'b0, irq_ack}, 32'd4);
      reset = 1'b1;
      #1;
      chk("midvec_ctl", {25'b0, ctl()}, {25'b0, C_IDLE});
      chk("midvec_ack", {28'b0, irq_ack}, 32'd0);
      chk("midvec_inten", {31'b0, int_en}, 32'd1);
      chk("midvec_cause", {29'b0, cause}, 32'd0);
      chk_s2_free("midvec_s2");
      @(posedge clock); #1;
      reset = 1'b0; irq = 4'b0;
      m_int_en = 1'b1; m_cause = 3'd0;
      tick();
      chk("midvec_after_ctl", {25'b0, ctl()}, {25'b0, C_IDLE});

      // Random traffic with idle gaps where requests arrive without instr_done.
      for (int k = 0; k < 150; k++) begin
         int          g;
         logic        t, r;
         logic [3:0]  iv;
         g = $urandom_range(0, 2);
         for (int j = 0; j < g; j++) begin
            trap_req = 1'($urandom); rfe_req = 1'($urandom); irq = 4'($urandom);
            tick();
            chk("gap_ctl", {25'b0, ctl()}, {25'b0, C_IDLE});
            chk("gap_inten", {31'b0, int_en}, {31'b0, m_int_en});
         end
         trap_req = 1'b0; rfe_req = 1'b0;
         if ($urandom_range(0, 3) == 0) pc = $urandom & 32'hFFFF_FFFC;
         t  = ($urandom_range(0, 5) == 0);
         r  = ($urandom_range(0, 3) == 0);
         iv = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
         do_instr(t, r, iv, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
